// File: rtl/fuzzy_rule_seq_pkg.sv
// Shared definitions for the serial fuzzy rule sequencer: widths, state
// encoding, the default 3x3 consequent table and the min operator.
package fuzzy_pkg;
    localparam int W_MU  = 16;
    localparam int W_C   = 16;
    localparam int NUM_W = W_MU + W_C + 4;
    localparam int DEN_W = W_MU + 4;

    typedef logic [3:0] rule_idx_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Rule k = 3*i + j holds C = 8192*(i+j-2); k=8 sits in the MSBs.
    localparam logic [9*W_C-1:0] CONSEQ_DEF = {
        16'h4000, 16'h2000, 16'h0000,
        16'h2000, 16'h0000, 16'hE000,
        16'h0000, 16'hE000, 16'hC000
    };

    // Fuzzy AND; on a tie either operand is equally correct.
    function automatic logic [W_MU-1:0] mu_min(input logic [W_MU-1:0] a,
                                               input logic [W_MU-1:0] b);
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/fuzzy_rule_mac.sv
// One rule evaluation per cycle: w = min(a, b), num += w*C, den += w.
// clr zeroes both accumulators, en adds the current rule.
module fuzzy_rule_mac
    import fuzzy_pkg::*;
#(
    parameter int MW = W_MU,
    parameter int CW = W_C,
    parameter int NW = MW + CW + 4,
    parameter int DW = MW + 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic [MW-1:0]        mu_a,
    input  logic [MW-1:0]        mu_b,
    input  logic signed [CW-1:0] conseq,
    output logic [MW-1:0]        w,
    output logic signed [NW-1:0] acc_num,
    output logic [DW-1:0]        acc_den
);
    logic signed [MW:0]    w_s;
    logic signed [MW+CW:0] prod;

    // Firing strength and its signed weighted consequent.
    always_comb begin
        w    = mu_min(mu_a, mu_b);
        w_s  = $signed({1'b0, w});
        prod = w_s * conseq;
    end

    // Accumulate; widths leave headroom for all nine rules at full scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_num <= '0;
            acc_den <= '0;
        end else if (clr) begin
            acc_num <= '0;
            acc_den <= '0;
        end else if (en) begin
            acc_num <= acc_num + NW'(prod);
            acc_den <= acc_den + DW'(w);
        end
    end
endmodule

// File: rtl/fuzzy_rule_seq.sv
// Serial 3x3 fuzzy rule evaluator: accepts six memberships, walks the nine
// rules through one min/MAC unit and presents num = sum(w*C), den = sum(w).
// Optional macro FUZZY_RULE_MASK_EN adds a per-rule enable port rule_mask.
module fuzzy_rule_seq #(
    parameter int              W_MU   = fuzzy_pkg::W_MU,
    parameter int              W_C    = fuzzy_pkg::W_C,
    parameter logic [9*W_C-1:0] CONSEQ = fuzzy_pkg::CONSEQ_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W_MU-1:0]            muT_neg,
    input  logic [W_MU-1:0]            muT_zero,
    input  logic [W_MU-1:0]            muT_pos,
    input  logic [W_MU-1:0]            muD_neg,
    input  logic [W_MU-1:0]            muD_zero,
    input  logic [W_MU-1:0]            muD_pos,
`ifdef FUZZY_RULE_MASK_EN
    input  logic [8:0]                 rule_mask,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [W_MU+W_C+3:0] num,
    output logic [W_MU+3:0]            den,
    output logic                       den_zero,
    output logic                       busy
);
    import fuzzy_pkg::*;

    localparam int NW = W_MU + W_C + 4;
    localparam int DW = W_MU + 4;

    state_t                 state;
    rule_idx_t              idx;
    logic [2:0][W_MU-1:0]   mu_t;
    logic [2:0][W_MU-1:0]   mu_d;
    logic [8:0]             mask;
    logic [1:0]             ti;
    logic [1:0]             dj;
    logic [W_MU-1:0]        op_a;
    logic [W_MU-1:0]        w;
    logic signed [W_C-1:0]  c_k;
    logic                   accept;
    logic                   any_w;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

`ifdef FUZZY_RULE_MASK_EN
    // Rule enables are captured together with the memberships.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mask <= '1;
        else if (accept) mask <= rule_mask;
    end
`else
    assign mask = '1;
`endif

    // Operand mux for rule idx; a masked rule sees a zero T membership so w=0.
    always_comb begin
        ti   = 2'(idx / 4'd3);
        dj   = 2'(idx % 4'd3);
        op_a = mask[idx] ? mu_t[ti] : '0;
        c_k  = CONSEQ[int'(idx)*W_C +: W_C];
    end

    fuzzy_rule_mac #(.MW(W_MU), .CW(W_C), .NW(NW), .DW(DW)) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .en      (state == RUN),
        .mu_a    (op_a),
        .mu_b    (mu_d[dj]),
        .conseq  (c_k),
        .w       (w),
        .acc_num (num),
        .acc_den (den)
    );

    // Control FSM: latch on accept, one rule per cycle, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            den_zero  <= 1'b0;
            busy      <= 1'b0;
            any_w     <= 1'b0;
            mu_t      <= '0;
            mu_d      <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mu_t     <= {muT_pos, muT_zero, muT_neg};
                    mu_d     <= {muD_pos, muD_zero, muD_neg};
                    idx      <= '0;
                    any_w    <= 1'b0;
                    den_zero <= 1'b0;
                    busy     <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    any_w <= any_w | (w != '0);
                    if (idx == rule_idx_t'(8)) begin
                        den_zero  <= !(any_w || (w != '0));
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fuzzy_rule_seq.sv
// Directed bench for fuzzy_rule_seq with hand-computed rule sums.
module tb_fuzzy_rule_seq;
    logic               clk = 1'b0;
    logic               rst_n, in_valid, in_ready, out_valid, out_ready, den_zero, busy;
    logic [15:0]        muT_neg, muT_zero, muT_pos, muD_neg, muD_zero, muD_pos;
    logic signed [35:0] num;
    logic [19:0]        den;
`ifdef FUZZY_RULE_MASK_EN
    logic [8:0]         rule_mask;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0]        tn, tz, tp, dn, dz, dp;
        logic signed [35:0] num;
        logic [19:0]        den;
        logic               zero;
        string              name;
    } vec_t;

    fuzzy_rule_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .muT_neg(muT_neg), .muT_zero(muT_zero), .muT_pos(muT_pos),
        .muD_neg(muD_neg), .muD_zero(muD_zero), .muD_pos(muD_pos),
`ifdef FUZZY_RULE_MASK_EN
        .rule_mask(rule_mask),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .num(num), .den(den),
        .den_zero(den_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic set_mu(input logic [15:0] tn, tz, tp, dn, dz, dp);
        muT_neg = tn; muT_zero = tz; muT_pos = tp;
        muD_neg = dn; muD_zero = dz; muD_pos = dp;
    endtask

    // Present a set and return just after the accepting edge.
    task automatic send(output bit ok);
        int t = 0;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
        ok = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid shows.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_mu(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
        n_checks++; if (num !== 36'sd0 || den !== 20'd0 || den_zero !== 1'b0) begin
            n_fail++; $display("FAIL reset_data: num=%0d den=%h dz=%b want 0 0 0", num, den, den_zero); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release: in_ready=%b want 1", in_ready); end
    endtask

    task automatic test_vectors();
        vec_t v[7];
        bit ok;
        int lat;
        v[0] = '{16'h0, 16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 16'h0, 36'sd0, 20'h0FFFF, 1'b0, "center"};
        v[1] = '{16'h0, 16'h0, 16'h8000, 16'h0, 16'h0, 16'hFFFF, 36'sh020000000, 20'h08000, 1'b0, "half_pos"};
        v[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 36'sd0, 20'h8FFF7, 1'b0, "all_ones"};
        v[3] = '{16'h1000, 16'h0, 16'h0, 16'h2000, 16'h0, 16'h0, -36'sd67108864, 20'h01000, 1'b0, "neg_corner"};
        v[4] = '{16'h0, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h4000, 36'sh008000000, 20'h04000, 1'b0, "tie"};
        v[5] = '{16'h3000, 16'h1000, 16'h0, 16'h2000, 16'h5000, 16'h0, -36'sd268435456, 20'h07000, 1'b0, "mixed"};
        v[6] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 36'sd0, 20'h0, 1'b1, "all_zero"};
        foreach (v[k]) begin
            set_mu(v[k].tn, v[k].tz, v[k].tp, v[k].dn, v[k].dz, v[k].dp);
            send(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL %s accept: in_ready never rose", v[k].name); end
            wait_out(lat);
            n_checks++; if (lat != 9) begin
                n_fail++; $display("FAIL %s latency: got %0d edges after accept, want 9", v[k].name, lat); end
            n_checks++; if (num !== v[k].num) begin
                n_fail++; $display("FAIL %s num: got %0d want %0d", v[k].name, num, v[k].num); end
            n_checks++; if (den !== v[k].den) begin
                n_fail++; $display("FAIL %s den: got %h want %h", v[k].name, den, v[k].den); end
            n_checks++; if (den_zero !== v[k].zero) begin
                n_fail++; $display("FAIL %s den_zero: got %b want %b", v[k].name, den_zero, v[k].zero); end
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL %s release: out_valid=%b busy=%b want 0 0", v[k].name, out_valid, busy); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        int bad = 0;
        out_ready = 1'b0;
        set_mu(16'h0, 16'h0, 16'h8000, 16'h0, 16'h0, 16'hFFFF);
        send(ok);
        wait_out(lat);
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL bp_first latency: got %0d want 9", lat); end
        set_mu(16'h0, 16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 16'h0);
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || num !== 36'sh020000000 || den !== 20'h08000 || den_zero !== 1'b0)
                bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: %0d unstable cycles, want 0", bad); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        set_mu(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_second_accept: busy=%b want 1", busy); end
        wait_out(lat);
        n_checks++; if (lat != 9 || num !== 36'sd0 || den !== 20'h0FFFF) begin
            n_fail++; $display("FAIL bp_second_result: lat=%0d num=%0d den=%h want 9 0 0ffff", lat, num, den); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int seen = 0;
        set_mu(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        send(ok);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || num !== 36'sd0 || den !== 20'd0 || den_zero !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_values: busy=%b rdy=%b ov=%b num=%0d den=%h dz=%b want 0 1 0 0 0 0",
                               busy, in_ready, out_valid, num, den, den_zero); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_no_output: %0d active cycles, want 0", seen); end
    endtask

`ifdef FUZZY_RULE_MASK_EN
    task automatic test_mask();
        bit ok;
        int lat;
        set_mu(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        rule_mask = 9'h010;
        send(ok);
        wait_out(lat);
        n_checks++; if (num !== 36'sd0 || den !== 20'h0FFFF || den_zero !== 1'b0) begin
            n_fail++; $display("FAIL mask_center: num=%0d den=%h dz=%b want 0 0ffff 0", num, den, den_zero); end
        @(posedge clk); #1;
        rule_mask = 9'h000;
        send(ok);
        wait_out(lat);
        n_checks++; if (num !== 36'sd0 || den !== 20'h0 || den_zero !== 1'b1) begin
            n_fail++; $display("FAIL mask_none: num=%0d den=%h dz=%b want 0 0 1", num, den, den_zero); end
        @(posedge clk); #1;
        rule_mask = 9'h1FF;
    endtask
`endif

    initial begin
`ifdef FUZZY_RULE_MASK_EN
        rule_mask = 9'h1FF;
`endif
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
`ifdef FUZZY_RULE_MASK_EN
        test_mask();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
